// File: rtl/bcd_multi_cnt.sv
// N-digit packed BCD up/down counter with programmable limits, wrap/stop policy,
// one-cycle carry pulse for cascading and a sticky done flag for timers.
module bcd_multi_cnt #(
   parameter int                  DIGITS    = 2,
   parameter logic [4*DIGITS-1:0] RST_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  dir,
   input  logic                  wrap,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   input  logic [4*DIGITS-1:0]   limit_lo,
   input  logic [4*DIGITS-1:0]   limit_hi,
   output logic [4*DIGITS-1:0]   value,
   output logic                  carry,
   output logic                  at_limit,
   output logic                  done
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] value_q, value_d;
   logic         carry_q, carry_d;
   logic         done_q, done_d;
   logic         terminal;

   // Ripple a +/-1 through the digits; a digit that rolls over passes the carry/borrow on.
   function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
      logic [W-1:0] r;
      logic         c;
      logic [3:0]   d;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (c) begin
            if (up) begin
               if (d >= 4'd9) r[4*i +: 4] = 4'd0;
               else begin
                  r[4*i +: 4] = d + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (d == 4'd0) r[4*i +: 4] = 4'd9;
               else begin
                  r[4*i +: 4] = d - 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   // Out-of-range values in the counting direction count as terminal.
   assign terminal = dir ? (value_q >= limit_hi) : (value_q <= limit_lo);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
      value_d = value_q;
      carry_d = 1'b0;
      done_d  = done_q;
      if (load) begin
         value_d = bcd_clamp(load_value);
         done_d  = 1'b0;
      end else if (en) begin
         if (!terminal) begin
            value_d = bcd_step(value_q, dir);
         end else if (wrap) begin
            value_d = dir ? limit_lo : limit_hi;
            carry_d = 1'b1;
         end else begin
            done_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= RST_VALUE;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign value    = value_q;
   assign carry    = carry_q;
   assign done     = done_q;
   assign at_limit = dir ? (value_q == limit_hi) : (value_q == limit_lo);

endmodule

// File: doc/bcd_multi_cnt.md
Name: bcd_multi_cnt

Overview:
Parametrised N-digit BCD counter for clock, stopwatch and countdown-timer datapaths. It counts up or down per enable pulse between programmable low and high limits, with a selectable wrap or stop-at-terminal policy. It emits a one-cycle carry/borrow pulse for cascading into the next stage, and a sticky done flag for timers. It supersedes the fixed two-digit down-counter pairs: one instance covers seconds, minutes or hours at any digit count.

Parameters:
DIGITS, 2, number of BCD digits; counter width is 4*DIGITS.
RST_VALUE, 0, packed BCD value loaded on reset; must be valid BCD and DIGITS digits wide.

Ports:
clk  input  1  global clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  count request, one step per cycle it is high
dir  input  1  1 = count up, 0 = count down
wrap  input  1  1 = wrap at terminal, 0 = stop and hold at terminal
load  input  1  load load_value this cycle
load_value  input  4*DIGITS  packed BCD value to load, digit 0 in [3:0]
limit_lo  input  4*DIGITS  packed BCD lower bound
limit_hi  input  4*DIGITS  packed BCD upper bound, must be >= limit_lo
value  output  4*DIGITS  registered packed BCD count
carry  output  1  registered one-cycle pulse on wrap (up overflow or down borrow)
at_limit  output  1  combinational: value == limit_hi when dir=1, value == limit_lo when dir=0
done  output  1  registered, sticky: a count request hit the terminal in stop mode

Behaviour:
- Reset (rst=1 at posedge): value <= RST_VALUE, carry <= 0, done <= 0. Reset overrides load and en.
- Priority per edge: rst > load > en. With no request, value holds and carry <= 0.
- Load: each load_value digit > 9 is clamped to 9 before storing. carry <= 0, done <= 0. An en asserted in the same cycle is ignored.
- Comparison: packed vectors are compared as unsigned binary. This is order-equivalent to BCD for valid digits.
- Terminal condition:
  - Up: value >= limit_hi.
  - Down: value <= limit_lo.
  - An out-of-range value in the counting direction is therefore treated as terminal.
- en with not terminal:
  - Up: BCD increment. Digit 9 becomes 0 and carries into the next digit.
  - Down: BCD decrement. Digit 0 becomes 9 and borrows from the next digit.
  - carry <= 0.
- en with terminal and wrap=1:
  - Up: value <= limit_lo.
  - Down: value <= limit_hi.
  - carry <= 1 for exactly the cycle in which value shows the wrap target.
  - done unchanged.
- en with terminal and wrap=0: value holds, carry <= 0, done <= 1.
- done clears only on rst or load. A dir or wrap change does not clear it.
- Consecutive en cycles at a one-value range (limit_lo == limit_hi) in wrap mode: value is constant and carry is high on every counted cycle.
- dir or wrap may change on any cycle. They take effect at the next edge, with no pipeline. at_limit follows dir immediately.
- Latency: value, carry and done are registered, one cycle from request. at_limit has zero latency.
- Cascading: drive the next stage's en from this stage's carry.
  - The next stage steps one cycle after this stage wraps.
  - Multi-stage carry ripple therefore costs one cycle per stage. This is acceptable for 1 Hz-class enables.
- Limits are sampled every cycle. Changing a limit mid-count takes effect on the next en, under the terminal rules above.

Test Plan:
- Reset and default: DIGITS=2, RST_VALUE=8'h00, rst=1 for one edge, then en=1, dir=1, wrap=1, lo=8'h00, hi=8'h59. Required: value 00 → 01 … 09 → 10 (BCD carry, never 0A). At 59 the next edge gives 00 with carry=1 for that single cycle.
- Down wrap timer: dir=0, lo=00, hi=59, load 8'h01, then en for 3 cycles. Required: value 00, then 59 with carry=1, then 58 with carry=0.
- Stop mode: dir=0, wrap=0, load 8'h02, en for 4 cycles. Required: value 01, then 00, then 00 twice. done rises on the third en and stays 1. A subsequent load of 8'h30 clears done and sets value to 30.
- Priority and clamping: load=1 with load_value=8'hAB, en=1, rst=0. Required: value 8'h99 and en ignored. Next, assert rst and load together: required value=RST_VALUE, done=0.
- Out-of-range and reconfiguration: DIGITS=3, lo=12'h001, hi=12'h012, load 12'h999, dir=1, wrap=1, en once. Required: value 001 and carry=1. Then set dir=0 at 001: at_limit=1 in the same cycle.
- Cascade: two instances, minutes.en driven by seconds.carry, both up with 00–59 and wrap. Required: after 60 seconds-enables from 00:00, minutes=01 one cycle after seconds wraps to 00.
